// File: rtl/mac_sched_pkg.sv
// Shared types and helpers for the mac_dot_sched dot-product sequencer.
// The sat_clamp helper exists only when MAC_SAT_EN is defined.
package mac_sched_pkg;

  localparam int unsigned LEN_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_e;

`ifdef MAC_SAT_EN
  // Wide enough to hold any product or sum the lane can form before clamping.
  localparam int unsigned SAT_MAX_W = 128;

  function automatic logic signed [SAT_MAX_W-1:0] sat_clamp(
    input  logic signed [SAT_MAX_W-1:0] v,
    input  int unsigned                 w,
    output logic                        clamped
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi        = (SAT_MAX_W'(1) <<< (w - 1)) - SAT_MAX_W'(1);
    lo        = ~hi;
    clamped   = 1'b0;
    sat_clamp = v;
    if (v > hi) begin
      sat_clamp = hi;
      clamped   = 1'b1;
    end else if (v < lo) begin
      sat_clamp = lo;
      clamped   = 1'b1;
    end
  endfunction
`endif

endpackage

// File: rtl/mac_lane.sv
// Two-stage signed multiply/accumulate lane: stage 1 registers a*b, stage 2 accumulates.
// MAC_SAT_EN selects clamping arithmetic with a sticky saturation flag; otherwise the add wraps.
module mac_lane
  import mac_sched_pkg::*;
#(
  parameter int unsigned D_W     = 32,
  parameter int unsigned D_W_ACC = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      first,
  input  logic signed [D_W-1:0]     a,
  input  logic signed [D_W-1:0]     b,
  output logic signed [D_W_ACC-1:0] acc,
  output logic                      sat
);

  logic signed [2*D_W-1:0]   prod_d;
  logic signed [2*D_W-1:0]   prod_q;
  logic                      vld_q;
  logic                      first_q;
  logic signed [D_W_ACC-1:0] ext_prod;
  logic signed [D_W_ACC-1:0] acc_d;
  logic signed [D_W_ACC-1:0] acc_q;

  assign prod_d = (2*D_W)'(a) * (2*D_W)'(b);

  // NOTE: pipeline data registers are reset too, so the lane never shows X even though vld gates their use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      prod_q  <= prod_d;
      vld_q   <= en;
      first_q <= first;
      acc_q   <= acc_d;
    end
  end

`ifdef MAC_SAT_EN
  logic                        sat_d;
  logic                        sat_q;
  logic                        clamp_ext;
  logic                        clamp_add;
  logic signed [SAT_MAX_W-1:0] ext_w;
  logic signed [SAT_MAX_W-1:0] sum_w;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ext_w    = sat_clamp(SAT_MAX_W'(prod_q), D_W_ACC, clamp_ext);
    ext_prod = D_W_ACC'(ext_w);
    sum_w    = sat_clamp(SAT_MAX_W'(acc_q) + SAT_MAX_W'(ext_prod), D_W_ACC, clamp_add);
    acc_d    = acc_q;
    sat_d    = sat_q;
    if (vld_q) begin
      if (first_q) begin
        acc_d = ext_prod;
        sat_d = clamp_ext;
      end else begin
        acc_d = D_W_ACC'(sum_w);
        sat_d = sat_q | clamp_ext | clamp_add;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end

  assign sat = sat_q;
`else
  always_comb begin
    ext_prod = D_W_ACC'(prod_q);
    acc_d    = acc_q;
    if (vld_q) acc_d = first_q ? ext_prod : acc_q + ext_prod;
  end

  assign sat = 1'b0;
`endif

  assign acc = acc_q;

endmodule

// File: rtl/mac_dot_sched.sv
// Dot-product sequencer: FSM, element countdown and stream handshakes around one mac_lane.
// Optional saturation (m_sat) is enabled with the MAC_SAT_EN define.
module mac_dot_sched
  import mac_sched_pkg::*;
#(
  parameter int unsigned D_W     = 32,
  parameter int unsigned D_W_ACC = 32,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      abort,
  output logic                      busy,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [D_W-1:0]     s_a,
  input  logic signed [D_W-1:0]     s_b,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [D_W_ACC-1:0] m_result,
  output logic                      m_sat
);

  state_e             state_d;
  state_e             state_q;
  logic [LEN_W-1:0]   remain_d;
  logic [LEN_W-1:0]   remain_q;
  logic               first_d;
  logic               first_q;
  logic               zero_len_d;
  logic               zero_len_q;
  logic               beat;
  logic signed [D_W_ACC-1:0] lane_acc;
  logic               lane_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      first_q    <= 1'b0;
      zero_len_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      first_q    <= first_d;
      zero_len_q <= zero_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    remain_d   = remain_q;
    first_d    = first_q;
    zero_len_d = zero_len_q;
    s_ready    = (state_q == RUN) && !abort;
    beat       = s_ready && s_valid;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_len != '0) begin
            state_d    = RUN;
            remain_d   = cfg_len;
            first_d    = 1'b1;
            zero_len_d = 1'b0;
          end else begin
            state_d    = OUT;
            zero_len_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (beat) begin
          first_d  = 1'b0;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      // One bubble so the last product reaches the accumulator before it is presented.
      DRAIN: state_d = OUT;
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (abort) state_d = IDLE;
  end

  mac_lane #(
    .D_W     (D_W),
    .D_W_ACC (D_W_ACC)
  ) u_lane (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (beat),
    .first (first_q),
    .a     (s_a),
    .b     (s_b),
    .acc   (lane_acc),
    .sat   (lane_sat)
  );

  assign busy    = (state_q != IDLE);
  assign m_valid = (state_q == OUT);
  // A zero-length request never touches the lane, so its stale accumulator is masked.
  assign m_result = (m_valid && !zero_len_q) ? lane_acc : '0;
  assign m_sat    = m_valid && !zero_len_q && lane_sat;

endmodule

// File: tb/tb_mac_dot_sched.sv
// Self-checking bench for mac_dot_sched: directed scenarios plus randomized dot products
// checked against a plain-arithmetic model (define MAC_SAT_EN for the saturating build).
module tb_mac_dot_sched;

  localparam int D_W     = 32;
  localparam int D_W_ACC = 32;
  localparam int LEN_W   = 16;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      start = 1'b0;
  logic [LEN_W-1:0]          cfg_len = '0;
  logic                      abort = 1'b0;
  logic                      busy;
  logic                      s_valid = 1'b0;
  logic                      s_ready;
  logic signed [D_W-1:0]     s_a = '0;
  logic signed [D_W-1:0]     s_b = '0;
  logic                      m_valid;
  logic                      m_ready = 1'b0;
  logic signed [D_W_ACC-1:0] m_result;
  logic                      m_sat;

  int n_checks = 0;
  int n_fail   = 0;
  int va [32];
  int vb [32];
  int gap [32];

  always #5 clk = ~clk;

  mac_dot_sched #(
    .D_W     (D_W),
    .D_W_ACC (D_W_ACC),
    .LEN_W   (LEN_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cfg_len  (cfg_len),
    .abort    (abort),
    .busy     (busy),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_result (m_result),
    .m_sat    (m_sat)
  );

  function automatic longint clamp32(input longint v, output bit hit);
    hit = (v > MAXV) || (v < MINV);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference: sum of products; wraps mod 2^32 by default, clamps every step when saturating.
  function automatic void model(input int len, output logic [31:0] r, output logic s);
    longint acc;
    longint p;
    bit     h1;
    bit     h2;
    acc = 0;
    s   = 1'b0;
    for (int i = 0; i < len; i++) begin
      p = longint'(va[i]) * longint'(vb[i]);
`ifdef MAC_SAT_EN
      p = clamp32(p, h1);
      if (i == 0) begin
        acc = p;
        s   = h1;
      end else begin
        acc = clamp32(acc + p, h2);
        s   = s | h1 | h2;
      end
`else
      h1  = 1'b0;
      h2  = 1'b0;
      acc = acc + p;
`endif
    end
    r = acc[31:0];
  endfunction

  task automatic run_dot(input string name, input int len, input int ready_dly);
    logic [31:0] exp_res;
    logic        exp_sat;
    model(len, exp_res, exp_sat);
    @(negedge clk);
    start   = 1'b1;
    cfg_len = LEN_W'(len);
    @(negedge clk);
    start   = 1'b0;
    cfg_len = LEN_W'($urandom);
    for (int i = 0; i < len; i++) begin
      s_valid = 1'b0;
      s_a     = $urandom;
      s_b     = $urandom;
      repeat (gap[i]) @(negedge clk);
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      n_checks++;
      if (s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s s_ready beat %0d: got %b want 1", name, i, s_ready);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s drain: m_valid=%b s_ready=%b busy=%b want 0 0 1", name, m_valid, s_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s latency: m_valid=%b want 1 two cycles after last beat", name, m_valid);
    end
    for (int k = 0; k <= ready_dly; k++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_result !== exp_res || m_sat !== exp_sat || s_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s result hold %0d: v=%b res=%0d sat=%b rdy=%b busy=%b want 1 %0d %b 0 1",
                 name, k, m_valid, m_result, m_sat, s_ready, busy, $signed(exp_res), exp_sat);
      end
      if (k == ready_dly) m_ready = 1'b1;
      @(negedge clk);
    end
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: m_valid=%b busy=%b want 0 0", name, m_valid, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || m_sat !== 1'b0 || m_result !== '0) begin
      n_fail++;
      $display("FAIL reset: busy=%b s_ready=%b m_valid=%b m_sat=%b m_result=%0d want all 0",
               busy, s_ready, m_valid, m_sat, m_result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset idle: busy=%b m_valid=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      va[i]  = i + 1;
      vb[i]  = i + 5;
      gap[i] = 0;
    end
    run_dot("basic70", 4, 0);
  endtask

  task automatic test_gaps();
    va[0] = -3; va[1] = 4;  va[2] = -5;
    vb[0] = 7;  vb[1] = -2; vb[2] = 1;
    gap[0] = 0; gap[1] = 1; gap[2] = 2;
    run_dot("gaps_m34", 3, 2);
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    start   = 1'b1;
    cfg_len = '0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (m_valid !== 1'b1 || m_result !== '0 || busy !== 1'b1 || s_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_len hold %0d: v=%b res=%0d busy=%b rdy=%b want 1 0 1 0",
                 k, m_valid, m_result, busy, s_ready);
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    n_checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len release: m_valid=%b busy=%b want 0 0", m_valid, busy);
    end
  endtask

  task automatic test_abort();
    for (int i = 0; i < 8; i++) begin
      va[i] = 100 + i;
      vb[i] = 7;
    end
    @(negedge clk);
    start   = 1'b1;
    cfg_len = 16'd8;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_a     = va[i];
      s_b     = vb[i];
      @(negedge clk);
    end
    abort   = 1'b1;
    s_a     = va[3];
    s_b     = vb[3];
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort s_ready: got %b want 0", s_ready);
    end
    @(negedge clk);
    abort   = 1'b0;
    s_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort idle: busy=%b m_valid=%b want 0 0", busy, m_valid);
    end
    start   = 1'b1;
    abort   = 1'b1;
    cfg_len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL abort quiet %0d: busy=%b m_valid=%b want 0 0", k, busy, m_valid);
      end
      @(negedge clk);
    end
    va[0] = 2; va[1] = 2;
    vb[0] = 3; vb[1] = 3;
    gap[0] = 0; gap[1] = 0;
    run_dot("after_abort12", 2, 0);
  endtask

  task automatic test_wrap();
    va[0] = 32'h4000_0000; va[1] = 32'h4000_0000;
    vb[0] = 2;             vb[1] = 2;
    gap[0] = 0; gap[1] = 0;
    run_dot("overflow", 2, 1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start   = 1'b1;
    cfg_len = 16'd4;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_a     = 9;
    s_b     = 9;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || m_sat !== 1'b0 || m_result !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b s_ready=%b m_valid=%b m_sat=%b m_result=%0d want all 0",
               busy, s_ready, m_valid, m_sat, m_result);
    end
    @(negedge clk);
    s_valid = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_in_out();
    va[0] = 5; vb[0] = 6; gap[0] = 0;
    @(negedge clk);
    start   = 1'b1;
    cfg_len = 16'd1;
    @(negedge clk);
    start   = 1'b0;
    s_valid = 1'b1;
    s_a     = va[0];
    s_b     = vb[0];
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1 || m_result !== 30) begin
      n_fail++;
      $display("FAIL start_in_out result: v=%b res=%0d want 1 30", m_valid, m_result);
    end
    m_ready = 1'b1;
    start   = 1'b1;
    cfg_len = 16'd3;
    @(negedge clk);
    m_ready = 1'b0;
    start   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (busy !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL start_in_out ignored %0d: busy=%b m_valid=%b want 0 0", k, busy, m_valid);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int len;
    for (int t = 0; t < 25; t++) begin
      len = $urandom_range(12, 1);
      for (int i = 0; i < len; i++) begin
        if (t < 12) begin
          va[i] = $signed($urandom_range(2000, 0)) - 1000;
          vb[i] = $signed($urandom_range(2000, 0)) - 1000;
        end else begin
          va[i] = $urandom;
          vb[i] = $urandom;
        end
        gap[i] = $urandom_range(2, 0);
      end
      run_dot($sformatf("random%0d", t), len, $urandom_range(3, 0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_gaps();
    test_abort();
    test_wrap();
    test_async_reset();
    test_start_in_out();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
